// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one LINE_WIDTH-bit line read/write into a BEATS-long burst
// on the DRAM port and reports completion with a one-cycle resp_o.
module cacheline_adaptor #(
   parameter int unsigned LINE_WIDTH  = 256,
   parameter int unsigned BURST_WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LINE_WIDTH-1:0]  line_i,
   output logic [LINE_WIDTH-1:0]  line_o,
   input  logic [31:0]            address_i,
   input  logic                   read_i,
   input  logic                   write_i,
   output logic                   resp_o,
   input  logic [BURST_WIDTH-1:0] burst_i,
   output logic [BURST_WIDTH-1:0] burst_o,
   output logic [31:0]            address_o,
   output logic                   read_o,
   output logic                   write_o,
   input  logic                   resp_i
);

   localparam int unsigned BEATS = LINE_WIDTH / BURST_WIDTH;
   localparam int unsigned CNT_W = $clog2(BEATS);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   state_e                             state_q, state_d;
   logic [CNT_W-1:0]                   cnt_q;
   logic [BEATS-1:0][BURST_WIDTH-1:0]  buf_q;
   logic [BEATS-1:0][BURST_WIDTH-1:0]  rd_line;
   logic [LINE_WIDTH-1:0]              line_q;
   logic [31:0]                        addr_q;
   logic [31:0]                        addr_aligned;
   logic                               last_beat;

   assign addr_aligned = address_i & ~(32'(LINE_WIDTH / 8) - 32'd1);
   assign last_beat    = resp_i && (cnt_q == CNT_W'(BEATS - 1));

   // Line as it will look once the current beat lands; used to publish on the final beat.
   always_comb begin
      rd_line        = buf_q;
      rd_line[cnt_q] = burst_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (write_i) begin
               state_d = StWrite;
            end else if (read_i) begin
               state_d = StRead;
            end
         end
         StRead:  if (last_beat) state_d = StDone;
         StWrite: if (last_beat) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // line_q is separate from the burst buffer so a write never disturbs the last read line.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         buf_q  <= '0;
         line_q <= '0;
         addr_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (write_i) begin
                  buf_q  <= line_i;
                  addr_q <= addr_aligned;
                  cnt_q  <= '0;
               end else if (read_i) begin
                  addr_q <= addr_aligned;
                  cnt_q  <= '0;
               end
            end
            StRead: begin
               if (resp_i) begin
                  buf_q <= rd_line;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (last_beat) begin
                     line_q <= rd_line;
                  end
               end
            end
            StWrite: begin
               if (resp_i) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      read_o    = 1'b0;
      write_o   = 1'b0;
      resp_o    = 1'b0;
      burst_o   = '0;
      address_o = addr_q;
      line_o    = line_q;
      unique case (state_q)
         StRead:  read_o = 1'b1;
         StWrite: begin
            write_o = 1'b1;
            burst_o = buf_q[cnt_q];
         end
         StDone:  resp_o = 1'b1;
         default: ;
      endcase
   end

endmodule
